// File: rtl/dragster_config_sequencer.sv
// Replays a programmable {reg_addr, reg_value} table as SPI write commands to linescanner 0,
// then optionally linescanner 1. Define DRAGSTER_READBACK_VERIFY_EN to read back and compare each write.
module dragster_config_sequencer #(
   parameter int NUM_REGS       = 8,
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tbl_wr_en,
   input  logic [4:0]  tbl_addr,
   input  logic [14:0] tbl_wdata,
   input  logic        start,
   input  logic        dual,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [15:0] cmd_word,
   output logic        cmd_sensor,
   input  logic        cmd_done,
   input  logic [7:0]  rsp_data,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int IDX_W = $clog2(NUM_REGS);
   localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
   localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_DONE,
      GAP,
      NEXT,
`ifdef DRAGSTER_READBACK_VERIFY_EN
      FINISH,
      V_ISSUE,
      V_WAIT
`else
      FINISH
`endif
   } state_t;

   state_t             state_q;
   logic [14:0]        tbl_q [NUM_REGS];
   logic [IDX_W-1:0]   idx_q;
   logic               sensor_q;
   logic               dual_q;
   logic [GAP_W-1:0]   gap_q;
   logic [TMO_W-1:0]   tmo_q;
   logic               cmd_valid_q;
   logic [15:0]        cmd_word_q;
   logic               cmd_sensor_q;
   logic               busy_q;
   logic               done_q;
   logic               error_q;

   logic [14:0]        entry_d;
   logic [15:0]        cmd_word_d;
   logic               issuing_d;
   logic               waiting_d;
   state_t             wait_state_d;
   state_t             after_wait_d;
   state_t             after_gap_d;
   logic               rd_bad_d;
   logic               gap_end_d;
   logic               tmo_end_d;
   logic               last_idx_d;
   logic               tbl_hit_d;

   assign cmd_valid  = cmd_valid_q;
   assign cmd_word   = cmd_word_q;
   assign cmd_sensor = cmd_sensor_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;

`ifndef DRAGSTER_READBACK_VERIFY_EN
   logic unused_rsp;
   assign unused_rsp = ^rsp_data;
`endif

   // ISSUE/V_ISSUE and WAIT_DONE/V_WAIT share one handshake and one timeout path
   always_comb begin
      entry_d      = tbl_q[idx_q];
      cmd_word_d   = {1'b0, entry_d};
      issuing_d    = (state_q == ISSUE);
      waiting_d    = (state_q == WAIT_DONE);
      wait_state_d = WAIT_DONE;
      after_wait_d = GAP;
      after_gap_d  = NEXT;
      rd_bad_d     = 1'b0;
`ifdef DRAGSTER_READBACK_VERIFY_EN
      after_gap_d  = V_ISSUE;
      if (state_q == V_ISSUE) begin
         issuing_d    = 1'b1;
         cmd_word_d   = {1'b1, entry_d[14:8], 8'h00};
         wait_state_d = V_WAIT;
      end
      if (state_q == V_WAIT) begin
         waiting_d    = 1'b1;
         after_wait_d = NEXT;
         rd_bad_d     = (rsp_data != entry_d[7:0]);
      end
`endif
   end

   assign gap_end_d  = (GAP_CYCLES == 0) || (gap_q == GAP_W'(GAP_CYCLES - 1));
   assign tmo_end_d  = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
   assign last_idx_d = (idx_q == IDX_W'(NUM_REGS - 1));
   assign tbl_hit_d  = ({27'd0, tbl_addr} < 32'(NUM_REGS));

   // Writes only land in IDLE, so the table is frozen for a whole sequence
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) tbl_q[i] <= '0;
      end else if (tbl_wr_en && state_q == IDLE && tbl_hit_d) begin
         tbl_q[tbl_addr[IDX_W-1:0]] <= tbl_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         sensor_q     <= 1'b0;
         dual_q       <= 1'b0;
         gap_q        <= '0;
         tmo_q        <= '0;
         cmd_valid_q  <= 1'b0;
         cmd_word_q   <= '0;
         cmd_sensor_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (issuing_d) begin
            if (!cmd_valid_q) begin
               cmd_valid_q  <= 1'b1;
               cmd_word_q   <= cmd_word_d;
               cmd_sensor_q <= sensor_q;
            end else if (cmd_ready) begin
               cmd_valid_q <= 1'b0;
               tmo_q       <= '0;
               state_q     <= wait_state_d;
            end
         end else if (waiting_d) begin
            if (cmd_done) begin
               if (rd_bad_d) begin
                  error_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  gap_q   <= '0;
                  state_q <= after_wait_d;
               end
            end else if (tmo_end_d) begin
               error_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end else begin
               tmo_q <= tmo_q + 1'b1;
            end
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     dual_q   <= dual;
                     error_q  <= 1'b0;
                     idx_q    <= '0;
                     sensor_q <= 1'b0;
                     busy_q   <= 1'b1;
                     state_q  <= ISSUE;
                  end
               end
               GAP: begin
                  if (gap_end_d) state_q <= after_gap_d;
                  else           gap_q   <= gap_q + 1'b1;
               end
               NEXT: begin
                  if (!last_idx_d) begin
                     idx_q   <= idx_q + 1'b1;
                     state_q <= ISSUE;
                  end else if (!sensor_q && dual_q) begin
                     sensor_q <= 1'b1;
                     idx_q    <= '0;
                     state_q  <= ISSUE;
                  end else begin
                     state_q <= FINISH;
                  end
               end
               FINISH: begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dragster_config_sequencer.sv
// Scoreboard bench for dragster_config_sequencer: a responder plays the SPI manager,
// a monitor pops expected {sensor, cmd_word} entries on every handshake.
module tb_dragster_config_sequencer;

   localparam int N   = 8;
   localparam int GAP = 16;
   localparam int TMO = 512;
`ifdef DRAGSTER_READBACK_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        tbl_wr_en = 1'b0;
   logic [4:0]  tbl_addr = '0;
   logic [14:0] tbl_wdata = '0;
   logic        start = 1'b0;
   logic        dual = 1'b0;
   logic        cmd_ready = 1'b0;
   logic        cmd_done = 1'b0;
   logic [7:0]  rsp_data = '0;
   logic        cmd_valid, cmd_sensor, busy, done, error;
   logic [15:0] cmd_word;

   dragster_config_sequencer #(.NUM_REGS(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .tbl_wr_en(tbl_wr_en), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
      .start(start), .dual(dual), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_word(cmd_word),
      .cmd_sensor(cmd_sensor), .cmd_done(cmd_done), .rsp_data(rsp_data), .busy(busy), .done(done),
      .error(error));

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   logic [16:0] exp_q [$];
   logic [14:0] mtbl [N];
   bit          hold_ready = 0, no_done = 0, corrupt_en = 0;
   int          done_seen = 0, hs_seen = 0, cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: every entry in index order, sensor 0 then sensor 1, read-back after each write
   task automatic push_entry(input bit s, input int i);
      exp_q.push_back({s, 1'b0, mtbl[i]});
      if (VERIFY) exp_q.push_back({s, 1'b1, mtbl[i][14:8], 8'h00});
   endtask

   task automatic push_seq(input bit d);
      for (int s = 0; s <= int'(d); s++)
         for (int i = 0; i < N; i++) push_entry(s[0], i);
   endtask

   // Responder + monitor in one process so cmd_ready and the handshake sample never race
   logic        prev_v = 1'b0;
   logic [16:0] prev_cmd = '0;
   int          last_hs = -1, done_cd = 0, rd_n = 0;
   logic [7:0]  last_w = '0;
   always @(negedge clk) begin
      logic [16:0] e;
      cyc++;
      if (reset) begin
         done_cd = 0; last_hs = -1; prev_v = 1'b0; rd_n = 0; cmd_done = 1'b0;
      end else begin
         if (prev_v) begin
            chk("valid_held", {31'd0, cmd_valid}, 32'd1);
            chk("word_held", {15'd0, cmd_sensor, cmd_word}, {15'd0, prev_cmd});
         end
         if (done) done_seen++;
         cmd_ready = !hold_ready;
         cmd_done = 1'b0;
         if (done_cd > 0) begin
            done_cd--;
            if (done_cd == 0) cmd_done = 1'b1;
         end
         if (cmd_valid && cmd_ready) begin
            hs_seen++;
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_cmd: got %0h expected none", {cmd_sensor, cmd_word});
            end else begin
               e = exp_q.pop_front();
               chk("cmd", {15'd0, cmd_sensor, cmd_word}, {15'd0, e});
            end
            if (last_hs >= 0 && (!VERIFY || cmd_word[15]))
               chk("gap_ge", {31'd0, (cyc - last_hs) >= GAP}, 32'd1);
            last_hs = cyc;
            if (!no_done) done_cd = 5;
            if (cmd_word[15]) begin
               rsp_data = (corrupt_en && rd_n == 2) ? 8'hFF : last_w;
               rd_n++;
            end else begin
               last_w = cmd_word[7:0];
            end
         end
         prev_v   = cmd_valid && !cmd_ready;
         prev_cmd = {cmd_sensor, cmd_word};
         if (!busy) begin last_hs = -1; rd_n = 0; end
      end
   end

   task automatic write_tbl(input logic [4:0] a, input logic [14:0] d);
      tbl_wr_en = 1'b1; tbl_addr = a; tbl_wdata = d;
      @(posedge clk); #1;
      tbl_wr_en = 1'b0;
   endtask

   task automatic kick(input bit d);
      dual = d; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; tbl_wr_en = 1'b0;
      @(negedge clk);
      chk("busy_rise", {31'd0, busy}, 32'd1);
   endtask

   task automatic wait_idle(input int bound, input string nm);
      int n = 0;
      do begin @(negedge clk); n++; end while (busy && n < bound);
      if (busy) begin
         total++; bad++;
         $display("FAIL %s_timeout: busy still %0d after %0d cycles, required 0", nm, busy, n);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic end_checks(input string nm, input bit exp_err, input int d0, input int exp_d);
      chk({nm, "_error"}, {31'd0, error}, {31'd0, exp_err});
      chk({nm, "_done"}, done_seen - d0, exp_d);
      chk({nm, "_drained"}, exp_q.size(), 0);
   endtask

   initial begin
      int d0, t0, h0, n;
      logic [14:0] v;
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, t0, h0, n;
      logic [14:0] v;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_valid", {31'd0, cmd_valid}, 0);
      chk("rst_word", {16'd0, cmd_word}, 0);
      chk("rst_sensor", {31'd0, cmd_sensor}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_error", {31'd0, error}, 0);
      @(posedge clk); #1;

      // 1: fixed table, single sensor
      for (int i = 0; i < N; i++) begin
         mtbl[i] = {7'h10 + 7'(i), 8'hA0 + 8'(i)};
         write_tbl(5'(i), mtbl[i]);
      end
      push_seq(1'b0);
      d0 = done_seen;
      kick(1'b0);
      wait_idle(4000, "single");
      end_checks("single", 1'b0, d0, 1);

      // 2: random table, dropped out-of-range write, write+start same cycle, start/write while busy
      for (int i = 0; i < N; i++) begin
         mtbl[i] = 15'($urandom);
         write_tbl(5'(i), mtbl[i]);
      end
      write_tbl(5'(N + $urandom_range(0, 31 - N)), 15'($urandom));
      v = 15'($urandom);
      mtbl[0] = v;
      push_seq(1'b1);
      d0 = done_seen;
      tbl_wr_en = 1'b1; tbl_addr = 5'd0; tbl_wdata = v;
      kick(1'b1);
      repeat (30) @(posedge clk);
      #1;
      start = 1'b1; tbl_wr_en = 1'b1; tbl_addr = 5'd1; tbl_wdata = ~mtbl[1];
      @(posedge clk); #1;
      start = 1'b0; tbl_wr_en = 1'b0;
      wait_idle(8000, "dual");
      end_checks("dual", 1'b0, d0, 1);

      // 3: stalled cmd_ready holds the first command for 20 clocks
      hold_ready = 1;
      push_seq(1'b0);
      d0 = done_seen;
      kick(1'b0);
      n = 0;
      while (!cmd_valid && n < 20) begin @(negedge clk); n++; end
      chk("stall_valid_seen", {31'd0, cmd_valid}, 1);
      repeat (20) @(negedge clk);
      chk("stall_valid", {31'd0, cmd_valid}, 1);
      chk("stall_word", {15'd0, cmd_sensor, cmd_word}, {15'd0, 1'b0, 1'b0, mtbl[0]});
      @(posedge clk); #1;
      hold_ready = 0;
      wait_idle(4000, "stall");
      end_checks("stall", 1'b0, d0, 1);

      // 4: cmd_done never comes -> timeout error, then a clean rerun clears it
      no_done = 1;
      exp_q.push_back({1'b0, 1'b0, mtbl[0]});
      d0 = done_seen;
      t0 = cyc;
      kick(1'b0);
      wait_idle(TMO + 200, "tmo");
      end_checks("tmo", 1'b1, d0, 0);
      chk("tmo_len", {31'd0, (cyc - t0) >= TMO}, 1);
      no_done = 0;
      push_seq(1'b0);
      d0 = done_seen;
      kick(1'b0);
      chk("err_clear", {31'd0, error}, 0);
      wait_idle(4000, "rerun");
      end_checks("rerun", 1'b0, d0, 1);

      // 5: reset while entry 3 is in flight; table clears, restart from idx 0 sensor 0
      push_seq(1'b0);
      d0 = done_seen;
      h0 = hs_seen;
      kick(1'b0);
      n = 0;
      while (hs_seen - h0 < 4 && n < 2000) begin @(posedge clk); n++; end
      chk("mid_hs", {31'd0, hs_seen - h0 >= 4}, 1);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("mid_valid", {31'd0, cmd_valid}, 0);
      chk("mid_word", {16'd0, cmd_word}, 0);
      chk("mid_busy", {31'd0, busy}, 0);
      chk("mid_nodone", done_seen - d0, 0);
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) mtbl[i] = '0;
      push_seq(1'b1);
      d0 = done_seen;
      kick(1'b1);
      wait_idle(8000, "post_rst");
      end_checks("post_rst", 1'b0, d0, 1);

`ifdef DRAGSTER_READBACK_VERIFY_EN
      // 6: corrupted read-back of entry 2 aborts before entry 3
      for (int i = 0; i < N; i++) begin
         mtbl[i] = {7'h20 + 7'(i), 8'h5A ^ 8'(i)};
         write_tbl(5'(i), mtbl[i]);
      end
      @(posedge clk); #1;
      corrupt_en = 1;
      for (int i = 0; i < 3; i++) push_entry(1'b0, i);
      d0 = done_seen;
      kick(1'b0);
      wait_idle(4000, "rbv");
      end_checks("rbv", 1'b1, d0, 0);
      corrupt_en = 0;
`endif

      repeat (5) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
